// File: rtl/player_executor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : player_executor_pkg
// Description : Player instruction bus encoding shared by controller and executor.
// Revision    : 1.0 - initial release
// ============================================================================
package player_executor_pkg;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_IDG = 4'd3;
    localparam logic [3:0] OP_SDG = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int ARG_MSB = 11;
    localparam int ARG_LSB = 4;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_INVUL = 2'd1,
        ST_DEAD  = 2'd2
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/player_executor_move_clamp.sv
`default_nettype none
// ============================================================================
// Module      : move_clamp
// Description : One-axis step with saturation to [MIN,MAX]; combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module move_clamp #(
    parameter int         STEP    = 2,
    parameter int         MIN     = 0,
    parameter int         MAX     = 639,
    parameter logic [1:0] DEC_DIR = 2'd1,
    parameter logic [1:0] INC_DIR = 2'd3
) (
    input  logic [9:0] coord,
    input  logic [1:0] dir,
    input  logic       en,
    output logic [9:0] next
);

    localparam logic signed [10:0] C_STEP = 11'(STEP);
    localparam logic signed [10:0] C_MIN  = 11'(MIN);
    localparam logic signed [10:0] C_MAX  = 11'(MAX);

    logic signed [10:0] w_delta;
    logic signed [10:0] w_sum;

    always_comb begin
        w_delta = '0;
        if (en && dir == DEC_DIR) begin
            w_delta = -C_STEP;
        end else if (en && dir == INC_DIR) begin
            w_delta = C_STEP;
        end
        // Signed 11-bit sum so a step below zero clamps instead of wrapping.
        w_sum = $signed({1'b0, coord}) + w_delta;
        if (w_sum < C_MIN) begin
            next = C_MIN[9:0];
        end else if (w_sum > C_MAX) begin
            next = C_MAX[9:0];
        end else begin
            next = w_sum[9:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/player_executor.sv
`default_nettype none
// ============================================================================
// Module      : player_executor
// Description : Executes MOV/DPY/HPY on the player soul; reports death and HUD state.
// Revision    : 1.0 - initial release
// ============================================================================
module player_executor
    import player_executor_pkg::*;
#(
    parameter int MAX_HP       = 20,
    parameter int X_MIN        = 220,
    parameter int X_MAX        = 420,
    parameter int Y_MIN        = 240,
    parameter int Y_MAX        = 400,
    parameter int X_START      = 320,
    parameter int Y_START      = 320,
    parameter int STEP         = 2,
    parameter int MOVE_DIV     = 4,
    parameter int INVUL_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    input  logic        startDmg,
    input  logic        respawn,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic [7:0]  playerHP,
    output logic        isDeath,
    output logic        dmgAck,
    output logic        hitFlash
);

    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int INV_W = (INVUL_CYCLES > 1) ? $clog2(INVUL_CYCLES) : 1;
    localparam logic [INV_W-1:0] C_INV_LOAD = INV_W'(INVUL_CYCLES - 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(MOVE_DIV - 1);

    logic [3:0]  w_op;
    logic [7:0]  w_arg;
    logic        w_unused_pad;

    player_state_t    r_state, w_state_nxt;
    logic [7:0]       r_hp, w_hp_nxt;
    logic [INV_W-1:0] r_inv, w_inv_nxt;
    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x, r_y, w_x_step, w_y_step;
    logic             r_ack;
    logic             w_move, w_step;
    logic [8:0]       w_heal;

    assign w_op         = playerInstruction[OP_MSB:OP_LSB];
    assign w_arg        = playerInstruction[ARG_MSB:ARG_LSB];
    assign w_unused_pad = ^playerInstruction[3:0];

    assign w_move = isMove && (w_op == OP_MOV) && (r_state != ST_DEAD);
    // Divider at 0 means a step is due; directions above RIGHT are NOPs.
    assign w_step = w_move && (r_div == '0) && (w_arg[7:2] == 6'd0);
    assign w_heal = {1'b0, r_hp} + {1'b0, w_arg};

    move_clamp #(
        .STEP(STEP), .MIN(X_MIN), .MAX(X_MAX),
        .DEC_DIR(DIR_LEFT), .INC_DIR(DIR_RIGHT)
    ) u_clamp_x (
        .coord(r_x), .dir(w_arg[1:0]), .en(w_step), .next(w_x_step)
    );

    move_clamp #(
        .STEP(STEP), .MIN(Y_MIN), .MAX(Y_MAX),
        .DEC_DIR(DIR_UP), .INC_DIR(DIR_DOWN)
    ) u_clamp_y (
        .coord(r_y), .dir(w_arg[1:0]), .en(w_step), .next(w_y_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hp_nxt    = r_hp;
        w_inv_nxt   = r_inv;
        if (r_state == ST_INVUL) begin
            if (r_inv == '0) begin
                w_state_nxt = ST_ALIVE;
            end else begin
                w_inv_nxt = r_inv - 1'b1;
            end
        end
        if (startDmg && r_state != ST_DEAD) begin
            if (w_op == OP_DPY && r_state == ST_ALIVE && w_arg != 8'd0) begin
                if (w_arg >= r_hp) begin
                    w_hp_nxt    = 8'd0;
                    w_state_nxt = ST_DEAD;
                    w_inv_nxt   = '0;
                end else begin
                    w_hp_nxt    = r_hp - w_arg;
                    w_state_nxt = ST_INVUL;
                    w_inv_nxt   = C_INV_LOAD;
                end
            end else if (w_op == OP_HPY) begin
                w_hp_nxt = (w_heal > 9'(MAX_HP)) ? 8'(MAX_HP) : w_heal[7:0];
            end
        end
        if (respawn) begin
            w_state_nxt = ST_ALIVE;
            w_hp_nxt    = 8'(MAX_HP);
            w_inv_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ALIVE;
            r_hp    <= 8'(MAX_HP);
            r_inv   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hp    <= w_hp_nxt;
            r_inv   <= w_inv_nxt;
            r_ack   <= startDmg;
        end
    end

    // Position path is independent of the hit/heal path within a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || respawn) begin
            r_x   <= 10'(X_START);
            r_y   <= 10'(Y_START);
            r_div <= '0;
        end else begin
            if (w_step) begin
                r_x <= w_x_step;
                r_y <= w_y_step;
            end
            if (!w_move || r_div == C_DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign posX     = r_x;
    assign posY     = r_y;
    assign playerHP = r_hp;
    assign dmgAck   = r_ack;
    assign isDeath  = (r_state == ST_DEAD);
    assign hitFlash = (r_state == ST_INVUL);

endmodule
`default_nettype wire

// File: tb/tb_player_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_executor
// Description : Scoreboard bench for player_executor with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_executor;

    localparam int MAX_HP = 20, X_MIN = 220, X_MAX = 420, Y_MIN = 240, Y_MAX = 400;
    localparam int X_START = 320, Y_START = 320, STEP = 2, MOVE_DIV = 4, INVUL_CYCLES = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] playerInstruction = '0;
    logic        isMove = 1'b0, startDmg = 1'b0, respawn = 1'b0;
    logic [9:0]  posX, posY;
    logic [7:0]  playerHP;
    logic        isDeath, dmgAck, hitFlash;

    player_executor #(
        .MAX_HP(MAX_HP), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_START(X_START), .Y_START(Y_START), .STEP(STEP), .MOVE_DIV(MOVE_DIV),
        .INVUL_CYCLES(INVUL_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .playerInstruction(playerInstruction),
        .isMove(isMove), .startDmg(startDmg), .respawn(respawn),
        .posX(posX), .posY(posY), .playerHP(playerHP),
        .isDeath(isDeath), .dmgAck(dmgAck), .hitFlash(hitFlash)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, hp, death, ack, flash;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: plain integers, invulnerability kept as cycles remaining.
    int m_x, m_y, m_hp, m_div, m_inv, m_ack;
    bit m_dead;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(bit rn, logic [15:0] ins, bit mv, bit sd, bit rsp);
        int   op, arg;
        bit   was_inv;
        exp_t e;
        @(negedge clk);
        rst_n = rn; playerInstruction = ins; isMove = mv; startDmg = sd; respawn = rsp;
        op  = int'(ins[15:12]);
        arg = int'(ins[11:4]);
        if (!rn || rsp) begin
            m_x = X_START; m_y = Y_START; m_hp = MAX_HP;
            m_div = 0; m_inv = 0; m_dead = 0;
            m_ack = rn ? int'(sd) : 0;
        end else begin
            was_inv = (m_inv > 0);
            m_ack   = int'(sd);
            if (mv && op == 5 && !m_dead) begin
                if (m_div == 0) begin
                    case (arg)
                        0: m_y = (m_y - STEP < Y_MIN) ? Y_MIN : m_y - STEP;
                        1: m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
                        2: m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
                        3: m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
                        default: ;
                    endcase
                end
                m_div = (m_div + 1) % MOVE_DIV;
            end else begin
                m_div = 0;
            end
            if (was_inv) m_inv--;
            if (sd && !m_dead) begin
                if (op == 2 && !was_inv && arg > 0) begin
                    m_hp = (arg >= m_hp) ? 0 : m_hp - arg;
                    if (m_hp == 0) m_dead = 1;
                    else m_inv = INVUL_CYCLES;
                end else if (op == 1) begin
                    m_hp = (m_hp + arg > MAX_HP) ? MAX_HP : m_hp + arg;
                end
            end
        end
        e.x = m_x; e.y = m_y; e.hp = m_hp;
        e.death = int'(m_dead); e.ack = m_ack; e.flash = (m_inv > 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hold(logic [15:0] ins, bit mv, int n);
        for (int i = 0; i < n; i++) drive(1'b1, ins, mv, 1'b0, 1'b0);
    endtask

    // Monitor: each expected entry is compared with the outputs after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("posX",     int'(posX),     e.x);
                chk("posY",     int'(posY),     e.y);
                chk("playerHP", int'(playerHP), e.hp);
                chk("isDeath",  int'(isDeath),  e.death);
                chk("dmgAck",   int'(dmgAck),   e.ack);
                chk("hitFlash", int'(hitFlash), e.flash);
            end
        end
    end

    initial begin
        logic [15:0] ins;
        logic [3:0]  ops [13] = '{4'd5, 4'd5, 4'd5, 4'd2, 4'd2, 4'd1, 4'd1,
                                  4'd0, 4'd3, 4'd4, 4'd6, 4'd7, 4'd15};
        bit rn, mv, sd, rsp;
        logic [7:0] arg;

        repeat (3) drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(10);
        // Held move right: steps on 0, 4, 8, then run into the right wall.
        hold(16'h5030, 1'b1, 9);
        hold(16'h5030, 1'b1, 200);
        idle(2);
        // Hit, ignored hit during invulnerability, full window.
        drive(1'b1, 16'h2050, 1'b0, 1'b1, 1'b0);
        idle(9);
        drive(1'b1, 16'h2050, 1'b0, 1'b1, 1'b0);
        idle(45);
        // Saturating heal, lethal hit, frozen position.
        drive(1'b1, 16'h10A0, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 16'h21E0, 1'b0, 1'b1, 1'b0);
        hold(16'h5010, 1'b1, 10);
        // Respawn wins over a simultaneous hit.
        drive(1'b1, 16'h2030, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Reset mid-invulnerability with the divider at 2, then immediate step.
        drive(1'b1, 16'h2050, 1'b0, 1'b1, 1'b0);
        hold(16'h5000, 1'b1, 2);
        drive(1'b0, 16'h5000, 1'b1, 1'b0, 1'b0);
        hold(16'h5000, 1'b1, 3);
        // Walk to the top and left walls.
        hold(16'h5000, 1'b1, 340);
        hold(16'h5010, 1'b1, 220);
        idle(2);

        ins = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(0, 199) != 0);
            rsp = m_dead ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 9))
                    0:       arg = 8'($urandom_range(0, 255));
                    1, 2, 3: arg = 8'($urandom_range(0, 30));
                    default: arg = 8'($urandom_range(0, 4));
                endcase
                ins = {ops[$urandom_range(0, 12)], arg, 4'($urandom_range(0, 15))};
            end
            mv = ($urandom_range(0, 3) != 0);
            sd = ($urandom_range(0, 5) == 0);
            drive(rn, ins, mv, sd, rsp);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
